// File: rtl/fifo_stat.sv
// fifo_stat: synchronous FIFO with occupancy count, almost-full/almost-empty
// watermarks, selectable FWFT or registered read, synchronous flush and
// sticky overflow/underflow flags.
module fifo_stat #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 4,
  parameter bit          FWFT       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AfCnt    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AeCnt    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CntOne   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PtrOne   = ADDR_WIDTH'(1);

  // Watermarks must be ordered and reachable; stop elaboration otherwise.
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_level_check
    $fatal(1, "fifo_stat: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;

  // Status flags decode the registered count only.
  always_comb begin
    count        = count_q;
    empty        = (count_q == '0);
    full         = (count_q == DepthCnt);
    almost_empty = (count_q <= AeCnt);
    almost_full  = (count_q >= AfCnt);
    overflow     = overflow_q;
    underflow    = underflow_q;
    // Full+wr+rd drops the write; empty+wr+rd drops the read.
    wr_acc       = wr & ~full;
    rd_acc       = rd & ~empty;
  end

  // Next-state for pointers, occupancy and sticky error flags; clear wins over rd/wr.
  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      w_ptr_d     = '0;
      r_ptr_d     = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) w_ptr_d = w_ptr_q + PtrOne;
      if (rd_acc) r_ptr_d = r_ptr_q + PtrOne;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
      if (wr && full)  overflow_d  = 1'b1;
      if (rd && empty) underflow_d = 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && !clear && wr_acc) begin
      mem[w_ptr_q] <= w_data;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is presented combinationally; a read pops it.
    assign r_data  = mem[r_ptr_q];
    assign r_valid = ~empty;
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_valid_q;

    // Registered read: fetch the head on rd_acc; the old word wins on a same-address write.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else if (clear) begin
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= rd_acc;
        if (rd_acc) r_data_q <= mem[r_ptr_q];
      end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
  end

endmodule
